// File: rtl/dm_pkg.sv
// Shared definitions for the dm_banked byte-lane memory: FSM state
// encoding, default geometry and the per-lane merge helper.
package dm_pkg;

    localparam int DM_LANES = 4;
    localparam int DM_DEPTH = 4096;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } dm_state_e;

    // Byte-lane merge: an enabled lane takes the new byte, otherwise keeps the old one.
    function automatic logic [7:0] lane_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/dm_lane_ram.sv
// One byte lane of the dm_banked memory: DEPTH x 8 storage with a single
// read/write port. The registered output is write-first, so a write returns
// the freshly merged byte and a read returns the byte held at the edge.
module dm_lane_ram
    import dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    // Output byte for the next cycle: new byte when written, stored byte otherwise.
    always_comb begin
        rdata_d = lane_merge(mem_q[addr], wdata, we);
    end

    // Storage array has no reset; the top-level clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dm_banked.sv
// dm_banked: byte-lane data memory with a one-request-per-cycle port,
// one-cycle response latency and a power-on clear sweep.
// Optional write trace (wr_evt/wr_addr/wr_data plus a $display line) is
// built only when DM_BANKED_TRACE_EN is defined; otherwise the trace
// outputs are tied to zero.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   ST_CLEAR  | zeroing one word per cycle, requests not accepted
//   ST_IDLE   | ready, no request accepted last cycle
//   ST_ACTIVE | ready, a request was accepted last cycle
module dm_banked
    import dm_pkg::*;
#(
    parameter int LANES  = DM_LANES,
    parameter int DEPTH  = DM_DEPTH,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [LANES-1:0]     req_be,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [8*LANES-1:0]   req_wdata,
    output logic                 rsp_valid,
    output logic [8*LANES-1:0]   rsp_rdata,
    output logic                 rsp_err,
    output logic                 init_done,
    output logic                 wr_evt,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [8*LANES-1:0]   wr_data
);

    localparam int LANE_W = $clog2(LANES);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int HI     = LANE_W + IDX_W;
    localparam int DW     = 8 * LANES;

    dm_state_e        state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             init_done_q, init_done_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;

    logic             clearing;
    logic             accept;
    logic             in_range;
    logic             commit;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] ram_addr;
    logic [DW-1:0]    ram_word;

    assign clearing  = (state_q == ST_CLEAR);
    assign req_ready = !clearing;
    assign accept    = req_valid && req_ready;
    assign req_idx   = req_addr[HI-1:LANE_W];
    assign commit    = accept && req_we && in_range && (|req_be);
    assign ram_addr  = clearing ? clr_cnt_q : req_idx;

    // Address bits above the word index make the request out of range.
    if (HI < ADDR_W) begin : g_range
        assign in_range = ~|req_addr[ADDR_W-1:HI];
    end else begin : g_norange
        assign in_range = 1'b1;
    end

    // Byte-offset bits do not select anything.
    if (LANE_W > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^req_addr[LANE_W-1:0];
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic       lane_we;
        logic [7:0] lane_wdata;
        assign lane_we    = clearing || (commit && req_be[i]);
        assign lane_wdata = clearing ? 8'h00 : req_wdata[8*i +: 8];
        dm_lane_ram #(
            .DEPTH (DEPTH)
        ) u_lane_ram (
            .clk   (clk),
            .reset (reset),
            .we    (lane_we),
            .addr  (ram_addr),
            .wdata (lane_wdata),
            .rdata (ram_word[8*i +: 8])
        );
    end

    // Next state, clear-sweep counter and init flag.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d     = ST_IDLE;
                    clr_cnt_d   = '0;
                    init_done_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!accept) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Response qualifiers for the cycle after acceptance.
    always_comb begin
        rsp_valid_d = accept;
        rsp_err_d   = accept && (!in_range || (req_we && !(|req_be)));
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Errored responses carry zero data; good ones carry the lane RAM word.
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = (rsp_valid_q && !rsp_err_q) ? ram_word : '0;
    assign init_done = init_done_q;

`ifdef DM_BANKED_TRACE_EN
    logic              wr_evt_q, wr_evt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       trace_pc_q, trace_pc_d;

    // Trace capture; pc is a running count of committed writes.
    always_comb begin
        wr_evt_d   = commit;
        wr_addr_d  = commit ? (req_addr & ~ADDR_W'(LANES - 1)) : '0;
        trace_pc_d = trace_pc_q + {31'd0, wr_evt_q};
    end

    // Trace registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_evt_q   <= 1'b0;
            wr_addr_q  <= '0;
            trace_pc_q <= '0;
        end else begin
            wr_evt_q   <= wr_evt_d;
            wr_addr_q  <= wr_addr_d;
            trace_pc_q <= trace_pc_d;
        end
    end

    // Trace print of each committed write.
    always_ff @(posedge clk) begin
        if (wr_evt_q) begin
            $display("%0t@%0d: *%h <= %h", $time, trace_pc_q, wr_addr_q, wr_data);
        end
    end

    assign wr_evt  = wr_evt_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_evt_q ? ram_word : '0;
`else
    assign wr_evt  = 1'b0;
    assign wr_addr = '0;
    assign wr_data = '0;
`endif

endmodule

// File: tb/tb_dm_banked.sv
// Self-checking bench for dm_banked (LANES=4, DEPTH=16): reset and clear
// timing, a directed vector table, random traffic against a word-array
// model, and reset aborts mid-traffic and mid-clear.
`timescale 1ns/1ps
module tb_dm_banked;

    localparam int LANES  = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, init_done, wr_evt;
    logic [31:0] rsp_rdata, wr_addr, wr_data;

    dm_banked #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done),
        .wr_evt    (wr_evt),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl_mem [DEPTH];
    bit          mdl_ready = 1'b0;
    bit          exp_valid, exp_err, exp_evt;
    logic [31:0] exp_rdata, exp_waddr, exp_wdata;

    typedef struct {
        bit          v;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          e_valid;
        bit          e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    endtask

    // Word-level model of one request seen at an accepting edge.
    task automatic model_req(input bit v, input bit we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int idx;
        bit oor;
        exp_valid = v && mdl_ready;
        exp_err   = 1'b0;
        exp_rdata = '0;
        exp_evt   = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        if (!exp_valid) return;
        idx = int'((addr / LANES) % DEPTH);
        oor = (addr / (LANES * DEPTH)) != 0;
        if (oor || (we && be == 4'b0000)) begin
            exp_err = 1'b1;
            return;
        end
        if (we) begin
            for (int i = 0; i < LANES; i++)
                if (be[i]) mdl_mem[idx][8*i +: 8] = wdata[8*i +: 8];
            exp_evt   = 1'b1;
            exp_waddr = addr - (addr % LANES);
            exp_wdata = mdl_mem[idx];
        end
        exp_rdata = mdl_mem[idx];
    endtask

    task automatic check_rsp();
        chk("rsp_valid", rsp_valid, exp_valid);
        if (exp_valid) begin
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_rdata", rsp_rdata, exp_rdata);
        end
`ifdef DM_BANKED_TRACE_EN
        chk("trace", {wr_evt, wr_addr, wr_data}, {exp_evt, exp_waddr, exp_wdata});
`else
        chk("trace off", {wr_evt, wr_addr, wr_data}, '0);
`endif
    endtask

    // One request cycle: called at a negedge, returns at the next negedge.
    task automatic cycle(input bit v, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = v;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        chk("req_ready", req_ready, mdl_ready);
        @(posedge clk);
        model_req(v, we, be, addr, wdata);
        @(negedge clk);
        req_valid = 1'b0;
        check_rsp();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " reset outputs"},
            {req_ready, rsp_valid, rsp_err, init_done, wr_evt, rsp_rdata, wr_addr, wr_data}, '0);
    endtask

    // Release reset at a negedge; 16 windows not ready, ready/init_done on the 17th.
    task automatic release_and_check_clear(input string tag);
        reset = 1'b1;
        #1;
        for (int k = 1; k <= DEPTH; k++) begin
            chk($sformatf("%s clear win%0d ready/init", tag, k), {req_ready, init_done}, 2'b00);
            @(negedge clk);
        end
        chk({tag, " ready/init after clear"}, {req_ready, init_done}, 2'b11);
        mdl_ready = 1'b1;
    endtask

    task automatic rand_traffic(input int n);
        bit          v, we;
        logic [3:0]  be;
        logic [31:0] a, d;
        for (int k = 0; k < n; k++) begin
            v  = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 1) == 1);
            be = 4'($urandom_range(0, 15));
            d  = $urandom;
            if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 2)) * 4;
            else                           a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            a = a + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(6, 31));
            cycle(v, we, be, a, d);
        end
    endtask

    initial begin
        vecs[0]  = '{1, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF};
        vecs[1]  = '{1, 0, 4'h0, 32'h0000_0010, 32'h0,         1, 0, 32'hDEAD_BEEF};
        vecs[2]  = '{1, 1, 4'h4, 32'h0000_0010, 32'h00AA_0000, 1, 0, 32'hDEAA_BEEF};
        vecs[3]  = '{1, 0, 4'hF, 32'h0000_0013, 32'h0,         1, 0, 32'hDEAA_BEEF};
        vecs[4]  = '{1, 1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 1, 1, 32'h0};
        vecs[5]  = '{1, 1, 4'hF, 32'h4000_0000, 32'h1234_5678, 1, 1, 32'h0};
        vecs[6]  = '{1, 0, 4'hF, 32'h4000_0010, 32'h0,         1, 1, 32'h0};
        vecs[7]  = '{1, 0, 4'h0, 32'h0000_0010, 32'h0,         1, 0, 32'hDEAA_BEEF};
        vecs[8]  = '{1, 1, 4'hA, 32'h0000_003C, 32'h1122_3344, 1, 0, 32'h1100_3300};
        vecs[9]  = '{1, 0, 4'h0, 32'h0000_003C, 32'h0,         1, 0, 32'h1100_3300};
        vecs[10] = '{1, 1, 4'hF, 32'h0000_0040, 32'hAAAA_AAAA, 1, 1, 32'h0};
        vecs[11] = '{1, 0, 4'h0, 32'h0000_0000, 32'h0,         1, 0, 32'h0};
        vecs[12] = '{0, 0, 4'h0, 32'h0000_0000, 32'h0,         0, 0, 32'h0};
        vecs[13] = '{1, 0, 4'h0, 32'h0000_0004, 32'h0,         1, 0, 32'h0};

        mdl_clear();
        repeat (3) @(negedge clk);
        chk_reset_outs("por");
        release_and_check_clear("por");

        for (int k = 0; k < 14; k++) begin
            cycle(vecs[k].v, vecs[k].we, vecs[k].be, vecs[k].addr, vecs[k].wdata);
            chk($sformatf("vec%0d rsp_valid", k), rsp_valid, vecs[k].e_valid);
            if (vecs[k].e_valid) begin
                chk($sformatf("vec%0d rsp_err", k), rsp_err, vecs[k].e_err);
                chk($sformatf("vec%0d rsp_rdata", k), rsp_rdata, vecs[k].e_rdata);
            end
        end

        rand_traffic(300);

        // Reset lands right after a read is accepted: its response must vanish.
        cycle(1, 1, 4'hF, 32'h20, 32'hCAFE_F00D);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = 32'h20;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        mdl_ready = 1'b0;
        mdl_clear();
        #1;
        chk("dropped rsp_valid", rsp_valid, 1'b0);
        chk_reset_outs("mid traffic");

        // Partial clear sweep up to index 7, then reset again.
        @(negedge clk);
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("ready at clear idx 7", {req_ready, init_done}, 2'b00);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outs("mid clear");
        release_and_check_clear("restart");

        for (int w = 0; w < DEPTH; w++) cycle(1, 0, 4'hF, 32'(w * 4), 32'h0);
        rand_traffic(150);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_banked.md
DM_BANKED -- requirements
Module: dm_banked

Interface
REQ-001 The module SHALL have parameter LANES, default 4, giving the byte lanes per word (data width 8*LANES).
REQ-002 The module SHALL have parameter DEPTH, default 4096, giving the word count (power of two).
REQ-003 The module SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-004 The module SHALL have port clk  in  1  rising-edge clock.
REQ-005 The module SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 The module SHALL have port req_valid  in  1  request present.
REQ-007 The module SHALL have port req_ready  out  1  request accepted this cycle if valid.
REQ-008 The module SHALL have port req_we  in  1  1=write, 0=read.
REQ-009 The module SHALL have port req_be  in  LANES  byte enables, bit i = byte i.
REQ-010 The module SHALL have port req_addr  in  ADDR_W  byte address.
REQ-011 The module SHALL have port req_wdata  in  8*LANES  write data, lane-aligned.
REQ-012 The module SHALL have port rsp_valid  out  1  response pulse.
REQ-013 The module SHALL have port rsp_rdata  out  8*LANES  read word, or merged word for writes.
REQ-014 The module SHALL have port rsp_err  out  1  error qualifier for rsp_valid.
REQ-015 The module SHALL have port init_done  out  1  memory clear complete.
REQ-016 The module SHALL have port wr_evt  out  1  trace: write committed.
REQ-017 The module SHALL have port wr_addr  out  ADDR_W  trace: word-aligned address.
REQ-018 The module SHALL have port wr_data  out  8*LANES  trace: full post-write word.

Function
REQ-019 The word index SHALL be req_addr[log2(LANES)+log2(DEPTH)-1 : log2(LANES)], and the low log2(LANES) address bits SHALL be ignored.
REQ-020 An address with any bit above the index field set SHALL be out-of-range: no write, rsp_err=1, rsp_rdata=0.
REQ-021 A write with req_be==0 SHALL have no effect on memory and SHALL respond with rsp_err=1.
REQ-022 The FSM SHALL have states CLEAR, IDLE, ACTIVE: CLEAR->IDLE after the last clear word; IDLE->ACTIVE on an accepted request; ACTIVE->IDLE on a cycle with no accepted request.
REQ-023 CLEAR SHALL zero one word per cycle from index 0 to DEPTH-1 using a counter, keeping req_ready=0; init_done SHALL rise in the cycle IDLE is entered and stay 1 until reset.
REQ-024 In IDLE and ACTIVE, req_ready SHALL be 1, giving one request per cycle with no bubbles.
REQ-025 Read latency SHALL be 1: rsp_valid=1 in the cycle after acceptance, with rsp_rdata equal to the word value at the acceptance edge.
REQ-026 A write SHALL update only the enabled lanes at the acceptance edge; the next cycle SHALL carry rsp_valid=1 and rsp_rdata equal to the merged word.
REQ-027 A read accepted in the cycle after a write to the same word SHALL return the updated data.
REQ-028 Any be pattern, including non-contiguous, SHALL be legal.

Reset
REQ-029 While reset=0: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, wr_evt=0, wr_addr=0, wr_data=0, clear counter=0, state=CLEAR.
REQ-030 Reset asserted mid-CLEAR or mid-traffic SHALL abort all activity; the clear sweep SHALL restart from index 0 after deassertion, and pending responses SHALL be dropped.

Configuration
REQ-031 With DM_BANKED_TRACE_EN defined, each committed write SHALL pulse wr_evt for one cycle with wr_addr/wr_data, and SHALL print "<time>@<pc>: *<wr_addr> <= <wr_data>" via $display.
REQ-032 Without DM_BANKED_TRACE_EN, wr_evt, wr_addr and wr_data SHALL be constant 0, no $display SHALL exist, and no trace registers SHALL be inferred.

Structure
REQ-033 The shared package dm_pkg SHALL hold the state enum, the lane-merge function, and the default LANES/DEPTH constants.
REQ-034 The sub-module dm_lane_ram (one byte lane, DEPTH x 8, with write enable) SHALL be instantiated LANES times.

Verification
REQ-035 Reset release with DEPTH=16: req_ready=0 for 16 cycles, init_done=1 on cycle 17, and a read of any address returns 0.
REQ-036 Write addr 0x10, be=1111, data 0xDEADBEEF, then a back-to-back read of 0x10: rsp_rdata=0xDEADBEEF one cycle after each request.
REQ-037 Write addr 0x10, be=0100, data 0x00AA0000, over 0xDEADBEEF: rsp_rdata=0xDEAABEEF and wr_data=0xDEAABEEF (trace on).
REQ-038 Write with be=0000, then an out-of-range address 0x4000_0000 with DEPTH=4096: rsp_err=1 for both, and memory is unchanged.
REQ-039 Reset pulsed at clear index 7: after release the sweep restarts at 0, and init_done is delayed by a full DEPTH cycles.
REQ-040 A trace-off build shows wr_evt constantly 0 under a write stream.
